// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port memory: lock-aware round-robin grant,
// combinational memory drive and a READ_LATENCY-deep read-return pipeline.
module mem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);

  // Out-of-range latencies are clamped so the pipeline never degenerates.
  localparam int LAT = (READ_LATENCY < 1) ? 1 : ((READ_LATENCY > 3) ? 3 : READ_LATENCY);

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } lock_state_e;

  lock_state_e        lock_state_q, lock_state_d;
  logic               prio_q, prio_d;
  logic [LAT-1:0]     pipe_vld_q, pipe_vld_d;
  logic [LAT-1:0]     pipe_id_q, pipe_id_d;

  logic               grant_s;
  logic               win_s;
  logic               win_we_s;
  logic               win_lock_s;
  logic [ADDR_W-1:0]  win_addr_s;
  logic [DATA_W-1:0]  win_data_s;

  // Lock owner first, then a lone requester, then prio on contention.
  always_comb begin
    grant_s = 1'b0;
    win_s   = 1'b0;
    if (reset) begin
      grant_s = 1'b0;
      win_s   = 1'b0;
    end else if ((lock_state_q == ST_LOCK0) && req0) begin
      grant_s = 1'b1;
      win_s   = 1'b0;
    end else if ((lock_state_q == ST_LOCK1) && req1) begin
      grant_s = 1'b1;
      win_s   = 1'b1;
    end else if (req0 && req1) begin
      grant_s = 1'b1;
      win_s   = prio_q;
    end else if (req0) begin
      grant_s = 1'b1;
      win_s   = 1'b0;
    end else if (req1) begin
      grant_s = 1'b1;
      win_s   = 1'b1;
    end else begin
      grant_s = 1'b0;
      win_s   = 1'b0;
    end
  end

  always_comb begin
    win_we_s   = 1'b0;
    win_lock_s = 1'b0;
    win_addr_s = {ADDR_W{1'b0}};
    win_data_s = {DATA_W{1'b0}};
    if (grant_s) begin
      case (win_s)
        1'b0: begin
          win_we_s   = we0;
          win_lock_s = lock0;
          win_addr_s = addr0;
          win_data_s = wdata0;
        end
        1'b1: begin
          win_we_s   = we1;
          win_lock_s = lock1;
          win_addr_s = addr1;
          win_data_s = wdata1;
        end
        default: begin
          win_we_s   = 1'b0;
          win_lock_s = 1'b0;
          win_addr_s = {ADDR_W{1'b0}};
          win_data_s = {DATA_W{1'b0}};
        end
      endcase
    end else begin
      win_we_s   = 1'b0;
      win_lock_s = 1'b0;
      win_addr_s = {ADDR_W{1'b0}};
      win_data_s = {DATA_W{1'b0}};
    end
  end

  assign gnt0        = grant_s & ~win_s;
  assign gnt1        = grant_s &  win_s;
  assign mem_address = win_addr_s;
  assign mem_data_in = win_data_s;
  assign mem_wren    = win_we_s;

  // Any cycle without a grant means the owner (if any) dropped its request,
  // and an unlocked grant ends ownership, so both paths release the lock.
  always_comb begin
    prio_d       = prio_q;
    lock_state_d = lock_state_q;
    if (grant_s) begin
      if (win_lock_s) begin
        lock_state_d = win_s ? ST_LOCK1 : ST_LOCK0;
        prio_d       = prio_q;
      end else begin
        lock_state_d = ST_FREE;
        prio_d       = ~win_s;
      end
    end else begin
      lock_state_d = ST_FREE;
      prio_d       = prio_q;
    end
  end

  always_comb begin
    pipe_vld_d    = {LAT{1'b0}};
    pipe_id_d     = {LAT{1'b0}};
    pipe_vld_d[0] = grant_s & ~win_we_s;
    pipe_id_d[0]  = win_s;
    for (int i = 1; i < LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_id_d[i]  = pipe_id_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q       <= 1'b0;
      lock_state_q <= ST_FREE;
      pipe_vld_q   <= {LAT{1'b0}};
      pipe_id_q    <= {LAT{1'b0}};
    end else begin
      prio_q       <= prio_d;
      lock_state_q <= lock_state_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_id_q    <= pipe_id_d;
    end
  end

  assign rvalid0 = pipe_vld_q[LAT-1] & ~pipe_id_q[LAT-1];
  assign rvalid1 = pipe_vld_q[LAT-1] &  pipe_id_q[LAT-1];
  assign rdata0  = mem_q;
  assign rdata1  = mem_q;
  assign busy    = |pipe_vld_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed vectors push expected read returns,
// a negedge monitor pops and checks them against rvalid/rdata.
module tb_mem_arbiter;
  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, we0, lock0, req1, we1, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_wren, busy;
  logic [DW-1:0] rdata0, rdata1, mem_data_in, mem_q;
  logic [AW-1:0] mem_address;

  typedef struct {
    int          cyc;
    logic        id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] rd_pipe [0:LAT-1];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_wren(mem_wren),
    .mem_q(mem_q), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: synchronous write, read data delayed LAT cycles.
  always @(posedge clk) begin
    if (mem_wren === 1'b1) mem[mem_address] <= mem_data_in;
    rd_pipe[0] <= mem[mem_address];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_q = rd_pipe[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_rvalid: got none expected id %0d at cycle %0d", sb[0].id, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (rvalid0 === 1'b1 && rvalid1 === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL both_rvalid: got rvalid0=1 rvalid1=1 expected at most one (cycle %0d)", cyc);
    end else if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rvalid1=%0b expected none (cycle %0d)", rvalid1, cyc);
      end else begin
        e = sb.pop_front();
        chk("rvalid_cycle", cyc, e.cyc);
        chk("rvalid_id", {31'd0, rvalid1}, {31'd0, e.id});
        chk("rdata", {16'd0, (rvalid1 ? rdata1 : rdata0)}, {16'd0, e.data});
      end
    end
  end

  task automatic step(input string name, input logic rs,
                      input logic r0, input logic w0, input logic l0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic r1, input logic w1, input logic l1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic eg0, input logic eg1, input logic [DW-1:0] erd, input bit push);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ew;
    @(posedge clk);
    #1;
    reset = rs;
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
    ea = eg0 ? a0 : (eg1 ? a1 : 8'h00);
    ed = eg0 ? d0 : (eg1 ? d1 : 16'h0000);
    ew = eg0 ? w0 : (eg1 ? w1 : 1'b0);
    @(negedge clk);
    chk({name, "_gnt0"}, {31'd0, gnt0}, {31'd0, eg0});
    chk({name, "_gnt1"}, {31'd0, gnt1}, {31'd0, eg1});
    chk({name, "_wren"}, {31'd0, mem_wren}, {31'd0, ew});
    chk({name, "_addr"}, {24'd0, mem_address}, {24'd0, ea});
    if (ew) chk({name, "_wdata"}, {16'd0, mem_data_in}, {16'd0, ed});
    else    chk({name, "_data0"}, {16'd0, mem_data_in}, 32'd0 | (eg0 | eg1 ? {16'd0, ed} : 32'd0));
    if (push && ((eg0 && !w0) || (eg1 && !w1))) sb.push_back('{cyc + LAT, eg1, erd});
  endtask

  task automatic idle();
    step("idle", 1'b0, 1'b0,1'b0,1'b0,8'h00,16'h0000, 1'b0,1'b0,1'b0,8'h00,16'h0000, 1'b0,1'b0,16'h0000, 1'b0);
  endtask

  task automatic drain(input string name);
    @(posedge clk);
    #1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    chk({name, "_drained"}, sb.size(), 32'd0);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    reset = 1'b1;
    req0 = 1'b0; we0 = 1'b0; lock0 = 1'b0; addr0 = 8'h00; wdata0 = 16'h0000;
    req1 = 1'b0; we1 = 1'b0; lock1 = 1'b0; addr1 = 8'h00; wdata1 = 16'h0000;

    // Requests ignored while reset is high
    step("rst_a", 1'b1, 1'b1,1'b1,1'b0,8'h10,16'h1111, 1'b1,1'b0,1'b0,8'h20,16'h2222, 1'b0,1'b0,16'h0000, 1'b0);
    step("rst_b", 1'b1, 1'b1,1'b1,1'b0,8'h10,16'h1111, 1'b1,1'b0,1'b0,8'h20,16'h2222, 1'b0,1'b0,16'h0000, 1'b0);

    // Single requester write then read-back; write-then-read same address
    step("wr0_10", 1'b0, 1'b1,1'b1,1'b0,8'h10,16'h1234, 1'b0,1'b0,1'b0,8'h00,16'h0000, 1'b1,1'b0,16'h0000, 1'b0);
    chk("busy_after_reset", {31'd0, busy}, 32'd0);
    step("rd0_10", 1'b0, 1'b1,1'b0,1'b0,8'h10,16'h0000, 1'b0,1'b0,1'b0,8'h00,16'h0000, 1'b1,1'b0,16'h1234, 1'b1);
    step("wr1_20", 1'b0, 1'b0,1'b0,1'b0,8'h00,16'h0000, 1'b1,1'b1,1'b0,8'h20,16'hBEEF, 1'b0,1'b1,16'h0000, 1'b0);
    step("wr0_30", 1'b0, 1'b1,1'b1,1'b0,8'h30,16'h5555, 1'b0,1'b0,1'b0,8'h00,16'h0000, 1'b1,1'b0,16'h0000, 1'b0);
    step("rd1_30", 1'b0, 1'b0,1'b0,1'b0,8'h00,16'h0000, 1'b1,1'b0,1'b0,8'h30,16'h0000, 1'b0,1'b1,16'h5555, 1'b1);
    drain("single");

    // Contention round-robin, prio starts at 0
    step("rr1", 1'b0, 1'b1,1'b0,1'b0,8'h10,16'h0000, 1'b1,1'b0,1'b0,8'h20,16'h0000, 1'b1,1'b0,16'h1234, 1'b1);
    step("rr2", 1'b0, 1'b1,1'b0,1'b0,8'h10,16'h0000, 1'b1,1'b0,1'b0,8'h20,16'h0000, 1'b0,1'b1,16'hBEEF, 1'b1);
    step("rr3", 1'b0, 1'b1,1'b0,1'b0,8'h10,16'h0000, 1'b1,1'b0,1'b0,8'h20,16'h0000, 1'b1,1'b0,16'h1234, 1'b1);
    step("rr4", 1'b0, 1'b1,1'b0,1'b0,8'h10,16'h0000, 1'b1,1'b0,1'b0,8'h20,16'h0000, 1'b0,1'b1,16'hBEEF, 1'b1);
    chk("busy_inflight", {31'd0, busy}, 32'd1);
    drain("rr");

    // Lock held by 0 for three transfers, released on the fourth
    for (int i = 0; i < 3; i++)
      step("lk0", 1'b0, 1'b1,1'b0,1'b1,8'h10,16'h0000, 1'b1,1'b0,1'b0,8'h20,16'h0000, 1'b1,1'b0,16'h1234, 1'b1);
    step("lk0_rel", 1'b0, 1'b1,1'b0,1'b0,8'h10,16'h0000, 1'b1,1'b0,1'b0,8'h20,16'h0000, 1'b1,1'b0,16'h1234, 1'b1);
    step("lk0_next", 1'b0, 1'b1,1'b0,1'b0,8'h10,16'h0000, 1'b1,1'b0,1'b0,8'h20,16'h0000, 1'b0,1'b1,16'hBEEF, 1'b1);

    // Owner 1 overrides prio=0, then drops req and loses the lock
    step("lk1_set", 1'b0, 1'b0,1'b0,1'b0,8'h00,16'h0000, 1'b1,1'b0,1'b1,8'h20,16'h0000, 1'b0,1'b1,16'hBEEF, 1'b1);
    step("lk1_hold", 1'b0, 1'b1,1'b0,1'b0,8'h10,16'h0000, 1'b1,1'b0,1'b1,8'h20,16'h0000, 1'b0,1'b1,16'hBEEF, 1'b1);
    step("lk1_drop", 1'b0, 1'b1,1'b0,1'b0,8'h10,16'h0000, 1'b0,1'b0,1'b0,8'h00,16'h0000, 1'b1,1'b0,16'h1234, 1'b1);
    step("solo1", 1'b0, 1'b0,1'b0,1'b0,8'h00,16'h0000, 1'b1,1'b0,1'b0,8'h20,16'h0000, 1'b0,1'b1,16'hBEEF, 1'b1);
    step("unlocked", 1'b0, 1'b1,1'b0,1'b0,8'h10,16'h0000, 1'b1,1'b0,1'b0,8'h20,16'h0000, 1'b1,1'b0,16'h1234, 1'b1);
    drain("lock");

    // Reset mid-flight: two reads discarded, prio (1 before) back to 0
    step("mf_t0", 1'b0, 1'b1,1'b0,1'b0,8'h10,16'h0000, 1'b0,1'b0,1'b0,8'h00,16'h0000, 1'b1,1'b0,16'h0000, 1'b0);
    step("mf_t1", 1'b0, 1'b1,1'b0,1'b0,8'h10,16'h0000, 1'b0,1'b0,1'b0,8'h00,16'h0000, 1'b1,1'b0,16'h0000, 1'b0);
    step("mf_rst", 1'b1, 1'b1,1'b1,1'b0,8'h50,16'h7777, 1'b1,1'b0,1'b0,8'h20,16'h0000, 1'b0,1'b0,16'h0000, 1'b0);
    step("mf_after", 1'b0, 1'b1,1'b0,1'b0,8'h10,16'h0000, 1'b1,1'b0,1'b0,8'h20,16'h0000, 1'b1,1'b0,16'h1234, 1'b1);
    chk("mf_busy", {31'd0, busy}, 32'd0);
    drain("midflight");

    // Idle for five cycles
    for (int i = 0; i < 5; i++) begin
      idle();
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end
    drain("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
